// File: rtl/dnn_0117.sv
// dnn_0117: fixed-point single-hidden-layer scorer for the word-detect chain.
// Captures N_IN signed 20-bit features, runs N_HID ReLU neurons and one
// output neuron on a single serial MAC, and emits a saturated 11-bit score.
// Weights and biases are the built-in default set.
module dnn_0117 #(
  parameter int N_IN  = 8,
  parameter int N_HID = 4,
  parameter int SHIFT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] vec_in,
  input  logic        dv_in,
  output logic [10:0] vec_out,
  output logic        dv_out
);

  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int HW = (N_HID > 1) ? $clog2(N_HID) : 1;
  localparam logic [IW-1:0] IN_LAST  = IW'(N_IN - 1);
  localparam logic [HW-1:0] HID_LAST = HW'(N_HID - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_L1_MAC = 3'd2;
  localparam logic [2:0] S_L1_ACT = 3'd3;
  localparam logic [2:0] S_L2_MAC = 3'd4;
  localparam logic [2:0] S_OUT    = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [IW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [HW-1:0]      hid_q, hid_d;
  logic signed [19:0] buf_q   [N_IN];
  logic signed [19:0] buf_d   [N_IN];
  logic signed [19:0] frame_q [N_IN];
  logic signed [19:0] frame_d [N_IN];
  logic signed [15:0] h_q     [N_HID];
  logic signed [15:0] h_d     [N_HID];
  logic signed [31:0] acc_q, acc_d;
  logic [10:0]        vec_out_q, vec_out_d;
  logic               dv_out_q, dv_out_d;

  logic signed [7:0]  w1_sel, w2_sel;
  logic signed [15:0] b1_sel, b2_sel;
  logic signed [27:0] prod1;
  logic signed [23:0] prod2;
  logic signed [31:0] acc_sh;
  logic signed [15:0] h_act;
  logic [10:0]        score;
  logic               frame_done, accept;

  // Built-in weights: neuron k sums features 2k and 2k+1; output is (h0+h1)-(h2+h3)
  always_comb begin
    w1_sel = 8'sd0;
    if ((int'(idx_q) / 2) == int'(hid_q)) w1_sel = 8'sd16;
    w2_sel = (int'(hid_q) < (N_HID / 2)) ? 8'sd16 : -8'sd16;
    b1_sel = 16'sd0;
    b2_sel = 16'sd0;
  end

  assign prod1  = frame_q[idx_q] * w1_sel;
  assign prod2  = h_q[hid_q] * w2_sel;
  assign acc_sh = acc_q >>> SHIFT;

  // ReLU with 16-bit clamp for the hidden layer, 11-bit saturation for the score
  always_comb begin
    h_act = 16'sd0;
    if (!acc_q[31]) begin
      if (acc_sh > 32'sd32767) h_act = 16'sh7FFF;
      else                     h_act = acc_sh[15:0];
    end
    score = acc_sh[10:0];
    if (acc_sh > 32'sd1023)       score = 11'h3FF;
    else if (acc_sh < -32'sd1024) score = 11'h400;
  end

  // Sample capture, frame hand-off and the serial MAC sequencer
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    hid_d      = hid_q;
    buf_d      = buf_q;
    frame_d    = frame_q;
    h_d        = h_q;
    acc_d      = acc_q;
    vec_out_d  = vec_out_q;
    dv_out_d   = 1'b0;
    frame_done = 1'b0;

    if (dv_in) begin
      buf_d[cnt_q] = vec_in;
      if (cnt_q == IN_LAST) begin
        cnt_d      = '0;
        frame_done = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // The OUT cycle no longer needs the frame, so a frame landing there is taken
    accept = frame_done && ((state_q == S_IDLE) || (state_q == S_OUT));
    if (accept) begin
      for (int i = 0; i < N_IN; i++) frame_d[i] = buf_d[i];
    end

    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_LOAD;
      end
      S_LOAD: begin
        acc_d   = 32'(b1_sel);
        idx_d   = '0;
        hid_d   = '0;
        state_d = S_L1_MAC;
      end
      S_L1_MAC: begin
        acc_d = acc_q + 32'(prod1);
        if (idx_q == IN_LAST) begin
          idx_d   = '0;
          state_d = S_L1_ACT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_L1_ACT: begin
        h_d[hid_q] = h_act;
        if (hid_q == HID_LAST) begin
          acc_d   = 32'(b2_sel);
          hid_d   = '0;
          state_d = S_L2_MAC;
        end else begin
          acc_d   = 32'(b1_sel);
          hid_d   = hid_q + 1'b1;
          state_d = S_L1_MAC;
        end
      end
      S_L2_MAC: begin
        acc_d = acc_q + 32'(prod2);
        if (hid_q == HID_LAST) begin
          hid_d   = '0;
          state_d = S_OUT;
        end else begin
          hid_d = hid_q + 1'b1;
        end
      end
      S_OUT: begin
        vec_out_d = score;
        dv_out_d  = 1'b1;
        state_d   = accept ? S_LOAD : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any partial frame or computation in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      hid_q     <= '0;
      acc_q     <= '0;
      vec_out_q <= '0;
      dv_out_q  <= 1'b0;
      for (int i = 0; i < N_IN; i++) begin
        buf_q[i]   <= '0;
        frame_q[i] <= '0;
      end
      for (int k = 0; k < N_HID; k++) h_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      hid_q     <= hid_d;
      acc_q     <= acc_d;
      vec_out_q <= vec_out_d;
      dv_out_q  <= dv_out_d;
      buf_q     <= buf_d;
      frame_q   <= frame_d;
      h_q       <= h_d;
    end
  end

  assign vec_out = vec_out_q;
  assign dv_out  = dv_out_q;

endmodule

// File: tb/tb_dnn_0117.sv
// tb_dnn_0117: directed bench for dnn_0117 with a scoreboard of expected
// scores and strobe cycles.
module tb_dnn_0117;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] vec_in = '0;
  logic        dv_in = 1'b0;
  logic [10:0] vec_out;
  logic        dv_out;

  typedef struct {
    logic [10:0] val;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   smp[8];
  int   last_accept = -1000;

  always #5 clk = ~clk;

  dnn_0117 dut (
    .clk    (clk),
    .reset  (reset),
    .vec_in (vec_in),
    .dv_in  (dv_in),
    .vec_out(vec_out),
    .dv_out (dv_out)
  );

  // Rising-edge counter used to time-stamp sample edges and score strobes
  always @(posedge clk) cyc <= cyc + 1;

  // Reference score for the current smp[] frame using the built-in weights
  function automatic logic [10:0] model_score();
    longint acc, acc2;
    longint h[4];
    for (int k = 0; k < 4; k++) begin
      acc = 0;
      for (int i = 0; i < 8; i++)
        if (i / 2 == k) acc += longint'(smp[i]) * 16;
      if (acc < 0) h[k] = 0;
      else begin
        h[k] = acc >>> 8;
        if (h[k] > 32767) h[k] = 32767;
      end
    end
    acc2 = 16 * h[0] + 16 * h[1] - 16 * h[2] - 16 * h[3];
    acc2 = acc2 >>> 8;
    if (acc2 > 1023) acc2 = 1023;
    if (acc2 < -1024) acc2 = -1024;
    return acc2[10:0];
  endfunction

  // Drive one frame on consecutive cycles and predict whether it is scored
  task automatic apply_stimulus();
    int last_edge;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      dv_in  = 1'b1;
      vec_in = smp[i][19:0];
    end
    last_edge = cyc + 1;
    if (last_edge >= last_accept + 42) begin
      last_accept = last_edge;
      sb.push_back('{val: model_score(), due: last_edge + 42});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      dv_in  = 1'b0;
      vec_in = '0;
    end
  endtask

  // Wait (bounded) for every predicted score to appear
  task automatic check_output(input string tag);
    for (int t = 0; t < 200 && sb.size() != 0; t++) idle(1);
    idle(3);
    checks++;
    assert (sb.size() === 0) else begin
      failures++;
      $error("[TB] FAIL %s_drain pending=%0d required=0", tag, sb.size());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    dv_in = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    last_accept = -1000;
    sb.delete();
  endtask

  task automatic check_reset_state(input string tag);
    checks++;
    assert (vec_out === 11'd0) else begin
      failures++;
      $error("[TB] FAIL %s_vec_out got=%0h required=0", tag, vec_out);
    end
    checks++;
    assert (dv_out === 1'b0) else begin
      failures++;
      $error("[TB] FAIL %s_dv_out got=%b required=0", tag, dv_out);
    end
  endtask

  // Every strobe must match the head of the scoreboard in value and cycle
  always @(negedge clk) begin
    if (!reset && dv_out === 1'b1) begin
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("[TB] FAIL unexpected_dv_out cyc=%0d got=%0h required=no_strobe", cyc, vec_out);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        assert (vec_out === e.val) else begin
          failures++;
          $error("[TB] FAIL score got=%0h required=%0h", vec_out, e.val);
        end
        checks++;
        assert (cyc === e.due) else begin
          failures++;
          $error("[TB] FAIL latency got_cyc=%0d required_cyc=%0d", cyc, e.due);
        end
      end
    end
  end

  initial begin
    $display("[TB] start");
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;
    idle(2);

    // All samples 256: every neuron is 32 and the score cancels to 0
    for (int i = 0; i < 8; i++) smp[i] = 256;
    apply_stimulus();
    check_output("all256");

    // First half 4096 -> +64
    for (int i = 0; i < 8; i++) smp[i] = (i < 4) ? 4096 : 0;
    apply_stimulus();
    check_output("pos64");

    // Second half 4096 -> -64
    for (int i = 0; i < 8; i++) smp[i] = (i < 4) ? 0 : 4096;
    apply_stimulus();
    check_output("neg64");

    // Hidden and output saturation
    for (int i = 0; i < 8; i++) smp[i] = (i < 4) ? 524287 : 0;
    apply_stimulus();
    check_output("sat");

    // ReLU clamps a negative neuron to 0
    for (int i = 0; i < 8; i++) smp[i] = (i < 2) ? -4096 : 0;
    apply_stimulus();
    check_output("relu");

    // Two frames exactly 42 cycles apart are both scored
    for (int i = 0; i < 8; i++) smp[i] = (i < 4) ? 4096 : 0;
    apply_stimulus();
    idle(34);
    for (int i = 0; i < 8; i++) smp[i] = (i < 4) ? 0 : 2048;
    apply_stimulus();
    check_output("period42");

    // 16 back-to-back samples: second frame is dropped
    for (int i = 0; i < 8; i++) smp[i] = (i < 4) ? 524287 : 0;
    apply_stimulus();
    for (int i = 0; i < 8; i++) smp[i] = 4096;
    apply_stimulus();
    check_output("burst");

    // Reset after 5 samples discards the partial frame
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      dv_in  = 1'b1;
      vec_in = 20'd9999;
    end
    do_reset();
    check_reset_state("abort_frame");
    for (int i = 0; i < 8; i++) smp[i] = int'($urandom_range(0, 16000)) - 8000;
    apply_stimulus();
    check_output("fresh");

    // Reset during computation suppresses the score
    for (int i = 0; i < 8; i++) smp[i] = (i < 4) ? 4096 : 0;
    apply_stimulus();
    idle(10);
    do_reset();
    check_reset_state("abort_compute");
    idle(60);
    for (int i = 0; i < 8; i++) smp[i] = (i < 4) ? 0 : 4096;
    apply_stimulus();
    check_output("recover");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
